// File: rtl/eth_num_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_num_pkg
// Brief    : ASCII byte constants and decoder FSM encoding shared by the
//            UDP decimal-field decoder and its accumulator.
// Revision : 1.0 - initial release
// ============================================================================
package eth_num_pkg;

    localparam logic [7:0] c_ascii_zero  = 8'h30;
    localparam logic [7:0] c_ascii_nine  = 8'h39;
    localparam logic [7:0] c_ascii_comma = 8'h2C;
    localparam logic [7:0] c_ascii_cr    = 8'h0D;
    localparam logic [7:0] c_ascii_lf    = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIELD = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= c_ascii_zero) && (b <= c_ascii_nine);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascii_field_acc.sv
`default_nettype none
// ============================================================================
// Module   : ascii_field_acc
// Brief    : Decimal digit accumulator with range and digit-count overflow.
// Revision : 1.0 - initial release
// ============================================================================
module ascii_field_acc
    import eth_num_pkg::*;
#(
    parameter int NUM_W      = 16,
    parameter int MAX_DIGITS = 5,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 2)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       i_data,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [NUM_W-1:0] o_acc,
    output logic [CNT_W-1:0] o_digit_cnt,
    output logic             o_ovf
);

    logic [NUM_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_W-1:0]   w_acc_base;
    logic [CNT_W-1:0]   w_cnt_base;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [NUM_W+3:0]   w_prod;

    // Clear and enable together start a field with this byte as its first digit.
    always_comb begin
        w_acc_base = i_clear ? '0 : r_acc;
        w_cnt_base = i_clear ? '0 : r_cnt;
        w_cnt_next = w_cnt_base + 1'b1;
        w_prod     = {4'b0000, w_acc_base} * (NUM_W + 4)'(10)
                   + (NUM_W + 4)'(i_data - c_ascii_zero);
    end

    assign o_ovf = i_enable && ((w_prod[NUM_W+3:NUM_W] != 4'd0) ||
                                (w_cnt_next > CNT_W'(MAX_DIGITS)));
    assign o_acc       = r_acc;
    assign o_digit_cnt = r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_enable) begin
            r_acc <= w_prod[NUM_W-1:0];
            r_cnt <= w_cnt_next;
        end else if (i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/udp_num_decoder.sv
`default_nettype none
// ============================================================================
// Module   : udp_num_decoder
// Brief    : Parses comma-separated ASCII decimal fields from a UDP payload
//            into per-channel values, committing only fully valid packets.
// Revision : 1.0 - initial release
// ============================================================================
module udp_num_decoder
    import eth_num_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int NUM_W      = 16,
    parameter int MAX_DIGITS = 5
) (
    input  logic                          rgmii_clk,
    input  logic                          rstn,
    input  logic                          udp_rec_data_valid,
    input  logic [7:0]                    udp_rec_rdata,
    input  logic [15:0]                   udp_rec_data_length,
    output logic [CH_NUM*NUM_W-1:0]       num,
    output logic                          num_vld,
    output logic [$clog2(CH_NUM+1)-1:0]   field_cnt,
    output logic                          err,
    output logic [15:0]                   pkt_ok_cnt,
    output logic [15:0]                   pkt_err_cnt
);

    localparam int FC_W  = $clog2(CH_NUM + 1);
    localparam int CNT_W = $clog2(MAX_DIGITS + 2);

    state_t                       r_state;
    logic [FC_W-1:0]              r_field_idx;
    logic [15:0]                  r_byte_cnt;
    logic [15:0]                  r_len;
    logic [NUM_W-1:0]             r_shadow [CH_NUM];
    logic [CH_NUM-1:0][NUM_W-1:0] r_num;
    logic                         r_num_vld;
    logic                         r_err;
    logic [FC_W-1:0]              r_field_cnt;
    logic [15:0]                  r_ok_cnt;
    logic [15:0]                  r_err_cnt;

    logic [NUM_W-1:0] w_acc;
    logic [CNT_W-1:0] w_digit_cnt;
    logic             w_ovf;
    logic             w_first, w_proc, w_end;
    logic             w_is_digit, w_is_sep, w_is_eol;
    logic             w_has_digits, w_sep_ok, w_byte_err, w_end_fail;

    assign w_first    = udp_rec_data_valid && (r_state == ST_IDLE);
    assign w_proc     = udp_rec_data_valid && (r_state != ST_DROP);
    assign w_end      = !udp_rec_data_valid && (r_state != ST_IDLE);
    assign w_is_digit = is_digit(udp_rec_rdata);
    assign w_is_sep   = (udp_rec_rdata == c_ascii_comma);
    assign w_is_eol   = (udp_rec_rdata == c_ascii_cr) || (udp_rec_rdata == c_ascii_lf);

    // The accumulator still holds the previous packet's count on a first byte.
    assign w_has_digits = !w_first && (w_digit_cnt != '0);
    assign w_sep_ok     = w_has_digits && (r_field_idx != FC_W'(CH_NUM - 1));
    assign w_byte_err   = w_is_digit ? w_ovf : (w_is_sep ? !w_sep_ok : !w_is_eol);
    assign w_end_fail   = (r_state == ST_DROP) || (r_byte_cnt != r_len) ||
                          (w_digit_cnt == '0);

    ascii_field_acc #(
        .NUM_W      (NUM_W),
        .MAX_DIGITS (MAX_DIGITS),
        .CNT_W      (CNT_W)
    ) u_acc (
        .clk         (rgmii_clk),
        .rstn        (rstn),
        .i_data      (udp_rec_rdata),
        .i_clear     (w_first || (w_proc && w_is_sep)),
        .i_enable    (w_proc && w_is_digit),
        .o_acc       (w_acc),
        .o_digit_cnt (w_digit_cnt),
        .o_ovf       (w_ovf)
    );

    always_ff @(posedge rgmii_clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_field_idx <= '0;
            r_byte_cnt  <= '0;
            r_len       <= '0;
            r_num       <= '0;
            r_num_vld   <= 1'b0;
            r_err       <= 1'b0;
            r_field_cnt <= '0;
            r_ok_cnt    <= '0;
            r_err_cnt   <= '0;
            for (int k = 0; k < CH_NUM; k++) r_shadow[k] <= '0;
        end else begin
            r_num_vld <= 1'b0;
            r_err     <= 1'b0;
            if (w_proc) begin
                if (w_first) begin
                    r_field_idx <= '0;
                    r_byte_cnt  <= 16'd1;
                    r_len       <= udp_rec_data_length;
                end else if (r_byte_cnt != 16'hFFFF) begin
                    r_byte_cnt <= r_byte_cnt + 16'd1;
                end
                r_state <= w_byte_err ? ST_DROP : ST_FIELD;
                if (w_is_sep && w_sep_ok) begin
                    for (int k = 0; k < CH_NUM; k++)
                        if (FC_W'(k) == r_field_idx) r_shadow[k] <= w_acc;
                    r_field_idx <= r_field_idx + 1'b1;
                end
            end else if (udp_rec_data_valid) begin
                if (r_byte_cnt != 16'hFFFF) r_byte_cnt <= r_byte_cnt + 16'd1;
            end else if (w_end) begin
                r_state <= ST_IDLE;
                if (w_end_fail) begin
                    r_err <= 1'b1;
                    if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                end else begin
                    // Last field is still in the accumulator, earlier ones in shadow.
                    for (int k = 0; k < CH_NUM; k++) begin
                        if (FC_W'(k) < r_field_idx)       r_num[k] <= r_shadow[k];
                        else if (FC_W'(k) == r_field_idx) r_num[k] <= w_acc;
                    end
                    r_field_cnt <= r_field_idx + 1'b1;
                    r_num_vld   <= 1'b1;
                    r_ok_cnt    <= r_ok_cnt + 16'd1;
                end
            end
        end
    end

    assign num         = r_num;
    assign num_vld     = r_num_vld;
    assign err         = r_err;
    assign field_cnt   = r_field_cnt;
    assign pkt_ok_cnt  = r_ok_cnt;
    assign pkt_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_udp_num_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_num_decoder
// Brief    : Self-checking bench for udp_num_decoder with a field-splitting
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_num_decoder;

    localparam int CH   = 4;
    localparam int NW   = 16;
    localparam int MAXD = 5;

    logic        clk;
    logic        rstn;
    logic        valid;
    logic [7:0]  rdata;
    logic [15:0] length;
    logic [63:0] num;
    logic        num_vld;
    logic [2:0]  field_cnt;
    logic        err;
    logic [15:0] pkt_ok_cnt;
    logic [15:0] pkt_err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_num;
    logic [2:0]  exp_fc;
    logic [15:0] exp_ok, exp_errc;
    logic        exp_vld, exp_errp;

    udp_num_decoder #(.CH_NUM(CH), .NUM_W(NW), .MAX_DIGITS(MAXD)) dut (
        .rgmii_clk           (clk),
        .rstn                (rstn),
        .udp_rec_data_valid  (valid),
        .udp_rec_rdata       (rdata),
        .udp_rec_data_length (length),
        .num                 (num),
        .num_vld             (num_vld),
        .field_cnt           (field_cnt),
        .err                 (err),
        .pkt_ok_cnt          (pkt_ok_cnt),
        .pkt_err_cnt         (pkt_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: drop CR/LF, split on commas, validate each field as a whole.
    function automatic void model_pkt(input string s, input int len, output bit ok,
                                      output int n, output logic [63:0] vals);
        int     fd[$];
        longint fv[$];
        bit     bad;
        bad = 0;
        fd.push_back(0);
        fv.push_back(0);
        for (int i = 0; i < s.len(); i++) begin
            byte unsigned c;
            c = s[i];
            if (c == 8'h0D || c == 8'h0A) continue;
            if (c == 8'h2C) begin
                fd.push_back(0);
                fv.push_back(0);
            end else if (c >= 8'h30 && c <= 8'h39) begin
                fd[fd.size()-1] = fd[fd.size()-1] + 1;
                fv[fv.size()-1] = fv[fv.size()-1] * 10 + longint'(c - 8'h30);
            end else begin
                bad = 1;
            end
        end
        ok = !bad && (len == s.len()) && (fd.size() <= CH);
        foreach (fd[i]) if (fd[i] < 1 || fd[i] > MAXD || fv[i] > 65535) ok = 0;
        n = fd.size();
        vals = '0;
        for (int i = 0; i < CH; i++)
            if (i < fd.size()) vals[i*NW +: NW] = fv[i][NW-1:0];
    endfunction

    task automatic apply_model(input string s, input int len);
        bit          ok;
        int          n;
        logic [63:0] vals;
        model_pkt(s, len, ok, n, vals);
        if (ok) begin
            for (int k = 0; k < n; k++) exp_num[k*NW +: NW] = vals[k*NW +: NW];
            exp_fc   = 3'(n);
            exp_ok   = exp_ok + 16'd1;
            exp_vld  = 1'b1;
            exp_errp = 1'b0;
        end else begin
            if (exp_errc != 16'hFFFF) exp_errc = exp_errc + 16'd1;
            exp_vld  = 1'b0;
            exp_errp = 1'b1;
        end
    endtask

    // Leaves time at #1 after the edge on which the result pulse appears.
    task automatic send_pkt(input string s, input int len);
        for (int i = 0; i < s.len(); i++) begin
            valid  = 1'b1;
            rdata  = s[i];
            length = len[15:0];
            @(posedge clk); #1;
        end
        valid = 1'b0;
        rdata = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic reset_model();
        exp_num = '0; exp_fc = '0; exp_ok = '0; exp_errc = '0;
        exp_vld = 1'b0; exp_errp = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; valid = 1'b0; rdata = '0; length = '0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({num, field_cnt, pkt_ok_cnt, pkt_err_cnt, num_vld, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: num=%h fc=%0d ok=%0d errc=%0d vld=%b err=%b, want all 0",
                     num, field_cnt, pkt_ok_cnt, pkt_err_cnt, num_vld, err);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        apply_model("7", 1);
        send_pkt("7", 1);
        n_tests++;
        if ({num_vld, err} !== 2'b10) begin
            n_fail++; $display("FAIL single_pulse: vld/err=%b%b want 10", num_vld, err);
        end
        n_tests++;
        if (num !== 64'd7 || field_cnt !== 3'd1 || num !== exp_num) begin
            n_fail++; $display("FAIL single_num: num=%h fc=%0d want %h fc=1", num, field_cnt, 64'd7);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({num_vld, err} !== 2'b00) begin
            n_fail++; $display("FAIL single_pulse_width: vld/err=%b%b want 00", num_vld, err);
        end
    endtask

    task automatic test_multi();
        string s;
        s = "12,345,6,65535\015\012";
        apply_model(s, 16);
        send_pkt(s, 16);
        n_tests++;
        if ({num_vld, err} !== 2'b10) begin
            n_fail++; $display("FAIL multi_pulse: vld/err=%b%b want 10", num_vld, err);
        end
        n_tests++;
        if (num !== {16'd65535, 16'd6, 16'd345, 16'd12} || num !== exp_num) begin
            n_fail++; $display("FAIL multi_num: num=%h want %h", num, {16'd65535, 16'd6, 16'd345, 16'd12});
        end
        n_tests++;
        if (field_cnt !== 3'd4 || pkt_ok_cnt !== 16'd2) begin
            n_fail++; $display("FAIL multi_cnt: fc=%0d ok=%0d want 4 2", field_cnt, pkt_ok_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_range_errors();
        string tbl[2];
        tbl = '{"70000", "000001"};
        foreach (tbl[i]) begin
            apply_model(tbl[i], tbl[i].len());
            send_pkt(tbl[i], tbl[i].len());
            n_tests++;
            if ({num_vld, err} !== 2'b01 || num !== exp_num) begin
                n_fail++;
                $display("FAIL range_err[%0d]: vld/err=%b%b num=%h want 01 %h", i, num_vld, err, num, exp_num);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (pkt_err_cnt !== 16'd2 || field_cnt !== 3'd4) begin
            n_fail++; $display("FAIL range_errcnt: errc=%0d fc=%0d want 2 4", pkt_err_cnt, field_cnt);
        end
    endtask

    task automatic test_format_errors();
        string tbl[4];
        tbl = '{"1,2,3,4,5", "1,,2", "1,", "1a"};
        foreach (tbl[i]) begin
            apply_model(tbl[i], tbl[i].len());
            send_pkt(tbl[i], tbl[i].len());
            n_tests++;
            if ({num_vld, err} !== 2'b01 || num !== {16'd65535, 16'd6, 16'd345, 16'd12}) begin
                n_fail++;
                $display("FAIL format_err[%0d]: vld/err=%b%b num=%h want 01 unchanged", i, num_vld, err, num);
            end
            @(posedge clk); #1;
        end
        n_tests++;
        if (pkt_err_cnt !== exp_errc || pkt_ok_cnt !== exp_ok) begin
            n_fail++; $display("FAIL format_cnt: errc=%0d ok=%0d want %0d %0d", pkt_err_cnt, pkt_ok_cnt, exp_errc, exp_ok);
        end
    endtask

    task automatic test_length_back_to_back();
        apply_model("42", 3);
        send_pkt("42", 3);
        n_tests++;
        if ({num_vld, err} !== 2'b01) begin
            n_fail++; $display("FAIL length_err: vld/err=%b%b want 01", num_vld, err);
        end
        apply_model("42", 2);
        send_pkt("42", 2);
        n_tests++;
        if ({num_vld, err} !== 2'b10 || num !== {16'd65535, 16'd6, 16'd345, 16'd42}) begin
            n_fail++; $display("FAIL back_to_back: vld/err=%b%b num=%h want 10 ch0=42", num_vld, err, num);
        end
        n_tests++;
        if (field_cnt !== 3'd1 || num !== exp_num) begin
            n_fail++; $display("FAIL back_to_back_fc: fc=%0d want 1", field_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_packet();
        bit pulse_seen;
        valid = 1'b1; rdata = 8'h39; length = 16'd2;
        @(posedge clk); #1;
        rdata = 8'h38;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        reset_model();
        n_tests++;
        if ({num, field_cnt, pkt_ok_cnt, pkt_err_cnt, num_vld, err} !== '0) begin
            n_fail++;
            $display("FAIL midreset_state: num=%h fc=%0d ok=%0d errc=%0d, want all 0",
                     num, field_cnt, pkt_ok_cnt, pkt_err_cnt);
        end
        valid = 1'b0; rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        pulse_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (num_vld || err) pulse_seen = 1;
        end
        n_tests++;
        if (pulse_seen) begin
            n_fail++; $display("FAIL midreset_nopulse: pulse seen=1 want 0");
        end
        apply_model("9", 1);
        send_pkt("9", 1);
        n_tests++;
        if ({num_vld, err} !== 2'b10 || num !== 64'd9 || pkt_ok_cnt !== 16'd1) begin
            n_fail++; $display("FAIL midreset_after: vld/err=%b%b num=%h ok=%0d want 10 9 1",
                               num_vld, err, num, pkt_ok_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int p = 0; p < 40; p++) begin
            string s;
            int    nf, len;
            s  = "";
            nf = $urandom_range(1, 5);
            for (int f = 0; f < nf; f++) begin
                int sel;
                sel = $urandom_range(0, 7);
                if (f > 0) s = {s, ","};
                if (sel == 0) begin
                    // empty field
                end else if (sel == 1) begin
                    for (int d = 0; d < 6; d++) s = {s, $sformatf("%0d", $urandom_range(0, 9))};
                end else begin
                    s = {s, $sformatf("%0d", $urandom_range(0, 70000))};
                end
            end
            if ($urandom_range(0, 9) == 0) s = {s, "x"};
            if ($urandom_range(0, 5) == 0) s = {s, "\015\012"};
            len = ($urandom_range(0, 7) == 0) ? s.len() + 1 : s.len();
            apply_model(s, len);
            send_pkt(s, len);
            n_tests++;
            if ({num_vld, err} !== {exp_vld, exp_errp}) begin
                n_fail++; $display("FAIL rand_pulse[%0d] \"%s\": vld/err=%b%b want %b%b",
                                   p, s, num_vld, err, exp_vld, exp_errp);
            end
            n_tests++;
            if (num !== exp_num || field_cnt !== exp_fc) begin
                n_fail++; $display("FAIL rand_num[%0d] \"%s\": num=%h fc=%0d want %h %0d",
                                   p, s, num, field_cnt, exp_num, exp_fc);
            end
            n_tests++;
            if (pkt_ok_cnt !== exp_ok || pkt_err_cnt !== exp_errc) begin
                n_fail++; $display("FAIL rand_cnt[%0d]: ok=%0d errc=%0d want %0d %0d",
                                   p, pkt_ok_cnt, pkt_err_cnt, exp_ok, exp_errc);
            end
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
                n_tests++;
                if ({num_vld, err} !== 2'b00) begin
                    n_fail++; $display("FAIL rand_pulse_width[%0d]: vld/err=%b%b want 00", p, num_vld, err);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_range_errors();
        test_format_errors();
        test_length_back_to_back();
        test_reset_mid_packet();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
